// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed data memory.
// Handles sub-word extraction/extension on loads and read-modify-write on sub-word stores.
module mem_access_unit #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespData,
  output logic        RespError,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData,
  output logic        MemRead,
  output logic        MemWrite
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state;
  state_t      next_state;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [1:0]  req_lane;
  logic [31:0] req_wdata;
  logic        req_error;
  logic [31:0] lane_data;
  logic [31:0] lane_mask;
  logic [31:0] load_data;
  logic [31:0] merged_data;

  // Misaligned, reserved-size and out-of-range requests bypass memory entirely.
  always_comb begin
    req_error = (ReqSize == 2'b11)
             || (ReqSize == 2'b01 && ReqAddr[0])
             || (ReqSize == 2'b10 && ReqAddr[1:0] != 2'b00)
             || ((ReqAddr >> (DEPTH_LOG2 + 2)) != 32'd0);
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    ReqReady   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RespValid  = 1'b0;
    case (state)
      IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          if (req_error)                         next_state = RESP;
          else if (ReqWrite && ReqSize == 2'b10) next_state = WRITE;
          else                                   next_state = READ;
        end
      end
      READ: begin
        MemRead    = 1'b1;
        next_state = req_write ? WRITE : RESP;
      end
      WRITE: begin
        MemWrite   = 1'b1;
        next_state = RESP;
      end
      RESP: begin
        RespValid = 1'b1;
        if (RespReady) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Addressed lane is shifted down to bit 0; half lanes use addr[1:0] = {h, 0}.
  always_comb begin
    lane_data = ReadData >> {req_lane, 3'b000};
    lane_mask = (req_size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << {req_lane, 3'b000};
    case (req_size)
      2'b00:   load_data = {{24{req_signed & lane_data[7]}}, lane_data[7:0]};
      2'b01:   load_data = {{16{req_signed & lane_data[15]}}, lane_data[15:0]};
      default: load_data = ReadData;
    endcase
    merged_data = (ReadData & ~lane_mask) | ((req_wdata << {req_lane, 3'b000}) & lane_mask);
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      req_write  <= 1'b0;
      req_size   <= 2'b00;
      req_signed <= 1'b0;
      req_lane   <= 2'b00;
      req_wdata  <= 32'd0;
      Address    <= 32'd0;
      WriteData  <= 32'd0;
      RespData   <= 32'd0;
      RespError  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            req_write  <= ReqWrite;
            req_size   <= ReqSize;
            req_signed <= ReqSigned;
            req_lane   <= ReqAddr[1:0];
            req_wdata  <= ReqWData;
            if (req_error) begin
              RespError <= 1'b1;
            end else begin
              Address <= {{(32 - DEPTH_LOG2){1'b0}}, ReqAddr[DEPTH_LOG2+1:2]};
              if (ReqWrite) WriteData <= ReqWData;
            end
          end
        end
        READ: begin
          if (req_write) WriteData <= merged_data;
          else           RespData  <= load_data;
        end
        RESP: begin
          if (RespReady) begin
            RespData  <= 32'd0;
            RespError <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
